// File: rtl/mlp_input_loader.sv
// Assembles IN_DIM DATA_W-bit features into one packed vector for the MLP core; MLP_LOADER_DBUF_EN adds a second bank.
// Latency: vec_valid rises the cycle after the final feature is accepted; all outputs registered.
// Backpressure: s_ready drops while every bank holds a complete vector; vec_out is held until vec_ready.
module mlp_input_loader #(
    parameter int IN_DIM = 64,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_last,
    output logic [DATA_W*IN_DIM-1:0] vec_out,
    output logic                     vec_valid,
    input  logic                     vec_ready,
    output logic                     frame_err,
    output logic [CNT_W-1:0]         vec_count
);
    localparam int IDX_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int VEC_W = DATA_W * IN_DIM;

    typedef enum logic {FILL, HOLD} state_t;

    state_t             r_state;
    state_t             w_nxt_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_nxt_idx;
    logic [VEC_W-1:0]   r_buf;
    logic [VEC_W-1:0]   r_vec;
    logic [VEC_W-1:0]   w_full_vec;
    logic [VEC_W-1:0]   w_nxt_vec;
    logic               r_s_ready;
    logic               r_vec_valid;
    logic               w_nxt_vec_valid;
    logic               r_frame_err;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_last_idx;
    logic               w_done;
    logic               w_drop;
    logic               w_err;

    assign w_in_xfer  = s_valid & r_s_ready;
    assign w_out_xfer = r_vec_valid & vec_ready;
    assign w_last_idx = (r_idx == IDX_W'(IN_DIM - 1));
    assign w_done     = w_in_xfer & w_last_idx;
    assign w_drop     = w_in_xfer & ~w_last_idx & s_last;
    assign w_err      = w_drop | (w_done & ~s_last);

    // Fill buffer with the incoming feature merged in; what a completing transfer publishes.
    always_comb begin
        w_full_vec = r_buf;
        w_full_vec[int'(r_idx)*DATA_W +: DATA_W] = s_data;
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_idx       = r_idx;
        w_nxt_vec       = r_vec;
        w_nxt_vec_valid = r_vec_valid;
        if (w_in_xfer) begin
            w_nxt_idx = (w_done || w_drop) ? '0 : r_idx + 1'b1;
        end
`ifdef MLP_LOADER_DBUF_EN
        // HOLD means the fill bank is also complete and waits behind vec_out.
        if (w_out_xfer) begin
            w_nxt_vec_valid = 1'b0;
        end
        case (r_state)
            FILL: begin
                if (w_done) begin
                    if (!r_vec_valid || w_out_xfer) begin
                        w_nxt_vec       = w_full_vec;
                        w_nxt_vec_valid = 1'b1;
                    end else begin
                        w_nxt_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_out_xfer) begin
                    w_nxt_vec       = r_buf;
                    w_nxt_vec_valid = 1'b1;
                    w_nxt_state     = FILL;
                end
            end
        endcase
`else
        case (r_state)
            FILL: begin
                if (w_done) begin
                    w_nxt_vec       = w_full_vec;
                    w_nxt_vec_valid = 1'b1;
                    w_nxt_state     = HOLD;
                end
            end
            HOLD: begin
                if (w_out_xfer) begin
                    w_nxt_vec_valid = 1'b0;
                    w_nxt_state     = FILL;
                end
            end
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_buf       <= '0;
            r_vec       <= '0;
            r_s_ready   <= 1'b0;
            r_vec_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_idx       <= w_nxt_idx;
            r_vec       <= w_nxt_vec;
            r_s_ready   <= (w_nxt_state == FILL);
            r_vec_valid <= w_nxt_vec_valid;
            r_frame_err <= w_err;
            if (w_in_xfer && !w_drop) begin
                r_buf <= w_full_vec;
            end
            if (w_out_xfer) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign s_ready   = r_s_ready;
    assign vec_out   = r_vec;
    assign vec_valid = r_vec_valid;
    assign frame_err = r_frame_err;
    assign vec_count = r_cnt;
endmodule

// File: tb/tb_mlp_input_loader.sv
// Scoreboard bench for mlp_input_loader (IN_DIM=4, DATA_W=8, CNT_W=3 to exercise counter wrap).
module tb_mlp_input_loader;
    localparam int IN_DIM = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;
`ifdef MLP_LOADER_DBUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [DATA_W-1:0]        s_data = '0;
    logic                     s_valid = 1'b0;
    logic                     s_ready;
    logic                     s_last = 1'b0;
    logic [DATA_W*IN_DIM-1:0] vec_out;
    logic                     vec_valid;
    logic                     vec_ready = 1'b0;
    logic                     frame_err;
    logic [CNT_W-1:0]         vec_count;

    mlp_input_loader #(.IN_DIM(IN_DIM), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .vec_out(vec_out), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .frame_err(frame_err), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int since_rst;
    int err_seen = 0;
    int rdy_mode = 2;
    int drv_pos = 0;

    // Reference model: pending partial vector, completed vectors awaiting delivery, delivery count.
    logic [7:0]  part[$];
    logic [31:0] exp_q[$];
    logic [CNT_W-1:0] m_cnt = '0;
    logic        exp_err = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [7:0] e0, input logic [7:0] e1,
                                         input logic [7:0] e2, input logic [7:0] e3);
        return {24'h0, e0} | ({24'h0, e1} << 8) | ({24'h0, e2} << 16) | ({24'h0, e3} << 24);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) since_rst <= 0;
        else        since_rst <= since_rst + 1;
    end

    // Monitor: inputs are stable at the falling edge, so this sees exactly the handshakes of the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("vec_valid", vec_valid, exp_q.size() != 0);
            if (since_rst == 0) chk("s_ready_after_reset", s_ready, 0);
            else                chk("s_ready", s_ready, exp_q.size() < DEPTH);
            chk("frame_err", frame_err, exp_err);
            chk("vec_count", vec_count, m_cnt);
            if (frame_err) err_seen++;
            if (vec_valid && exp_q.size() != 0) begin
                chk("vec_out", vec_out, exp_q[0]);
                if (vec_ready) begin
                    void'(exp_q.pop_front());
                    m_cnt = m_cnt + 1'b1;
                end
            end
            exp_err = 1'b0;
            if (s_valid && s_ready) begin
                if (part.size() == IN_DIM - 1) begin
                    exp_q.push_back(pack(part[0], part[1], part[2], s_data));
                    exp_err = ~s_last;
                    part.delete();
                end else if (s_last) begin
                    exp_err = 1'b1;
                    part.delete();
                end else begin
                    part.push_back(s_data);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       vec_ready = 1'($urandom_range(0, 1));
                1:       vec_ready = 1'b1;
                default: vec_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        logic acc;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        forever begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        drv_pos = (l || drv_pos == IN_DIM - 1) ? 0 : drv_pos + 1;
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_rdy(input int m);
        rdy_mode  = m;
        vec_ready = (m == 1);
    endtask

    int e0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vec_out", vec_out, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_vec_count", vec_count, 0);
        rst_n = 1'b1;

        // Basic fill, then hold under backpressure.
        @(posedge clk);
        #1;
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        @(negedge clk);
        chk("basic_vec_valid", vec_valid, 1);
        chk("basic_vec_out", vec_out, 32'h44332211);
        chk("basic_frame_err", frame_err, 0);
        repeat (10) begin
            @(negedge clk);
            chk("bp_vec_out", vec_out, 32'h44332211);
            chk("bp_vec_valid", vec_valid, 1);
            chk("bp_s_ready", s_ready, DEPTH == 2);
        end
        @(posedge clk);
        #1;
        set_rdy(1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_count", vec_count, 1);
        chk("bp_s_ready_after", s_ready, 1);
        chk("bp_vec_valid_after", vec_valid, 0);

        // Early s_last drops the partial vector.
        e0 = err_seen;
        send(8'hAA, 0); send(8'hBB, 1);
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
        drain();
        chk("early_err_pulses", err_seen - e0, 1);

        // Missing s_last: vector still issued, error aligned with vec_valid rise.
        e0 = err_seen;
        send(8'h5A, 0); send(8'h6B, 0); send(8'h7C, 0); send(8'h8D, 0);
        @(negedge clk);
        chk("miss_frame_err", frame_err, 1);
        chk("miss_vec_valid", vec_valid, 1);
        chk("miss_vec_out", vec_out, 32'h8D7C6B5A);
        drain();
        chk("miss_err_pulses", err_seen - e0, 1);

        // Reset in the middle of a fill.
        send(8'h01, 0); send(8'h02, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vec_out", vec_out, 0);
        chk("mid_rst_vec_valid", vec_valid, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_frame_err", frame_err, 0);
        chk("mid_rst_count", vec_count, 0);
        part.delete();
        exp_q.delete();
        m_cnt = '0;
        exp_err = 1'b0;
        drv_pos = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back streaming of three vectors.
        for (int i = 0; i < 3 * IN_DIM; i++) begin
            send(8'(8'h20 + i), (i % IN_DIM) == IN_DIM - 1);
        end
        drain();
        chk("stream_count", vec_count, 3);

        // Randomized traffic with occasional framing errors and random vec_ready.
        set_rdy(0);
        for (int i = 0; i < 240; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            if (drv_pos == IN_DIM - 1) send(8'($urandom), 1'($urandom_range(0, 9) != 0));
            else                       send(8'($urandom), 1'($urandom_range(0, 19) == 0));
        end
        set_rdy(1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mlp_input_loader.md
Name: mlp_input_loader

Overview:
- Producer side of the MLP core's packed input-vector bus.
- Accepts a stream of DATA_W-bit features over a valid/ready handshake and assembles IN_DIM of them into one packed vector.
- Presents the vector to the phase-1 MLP core with a valid/ready handshake, holding it stable until the core accepts.
- Sits between the external sample source (DMA/UART front end) and the hidden-layer datapath.

Parameters:
- IN_DIM, 64, features per vector (>=2).
- DATA_W, 8, bits per feature.
- CNT_W, 16, width of the accepted-vector counter.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  DATA_W  incoming feature.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept s_data.
- s_last  in  1  marks the final feature of a vector; qualified by s_valid.
- vec_out  out  DATA_W*IN_DIM  packed vector; element k at bits [k*DATA_W +: DATA_W].
- vec_valid  out  1  vec_out holds a complete vector.
- vec_ready  in  1  MLP core accepts vec_out.
- frame_err  out  1  one-cycle pulse on s_last/length mismatch.
- vec_count  out  CNT_W  number of vectors handed to the core (vec_valid & vec_ready), wrapping.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=FILL, idx=0.
  - vec_out=0, vec_valid=0, s_ready=0, frame_err=0, vec_count=0.
  - s_ready rises on the first clk edge after rst_n deasserts.
- Transfer handshakes:
  - Input transfer = s_valid & s_ready at the rising edge.
  - Output transfer = vec_valid & vec_ready at the rising edge.
  - All outputs are registered; there are no combinational paths from inputs to outputs.
- Ordering: the first feature accepted in a vector is element 0; idx increments per transfer.
- State FILL (s_ready=1, vec_valid=0):
  - Transfer with idx<IN_DIM-1 and s_last=0: write element idx, idx++.
  - Transfer with idx<IN_DIM-1 and s_last=1:
    - element is discarded and the partial vector dropped;
    - idx returns to 0; frame_err pulses the next cycle; stay in FILL.
  - Transfer with idx=IN_DIM-1:
    - write the element, idx returns to 0, go to HOLD;
    - next cycle vec_valid=1, s_ready=0;
    - if s_last=0, frame_err also pulses, but the vector is still issued.
  - No transfer: hold state.
- State HOLD (s_ready=0, vec_valid=1):
  - vec_out stays stable.
  - On output transfer: vec_valid=0, s_ready=1, vec_count++ (wraps at 2^CNT_W), return to FILL.
  - vec_ready may be held high continuously; vec_valid is never withdrawn without a transfer.
- Latency and throughput:
  - Final element accepted at edge N -> vec_valid high after edge N.
  - Single-buffer throughput is one vector per IN_DIM+1 cycles when both sides stream at full rate.
- s_data and s_last are ignored when s_valid=0.
- vec_out unused bits never contain stale data from a dropped partial vector: elements are only exposed through a completed fill.
- A partial vector in flight at reset is lost.

Optional Feature:
- Macro: MLP_LOADER_DBUF_EN.
- Defined: two vector banks (ping-pong).
  - Filling continues into the free bank while the other is held on vec_out.
  - s_ready deasserts only when both banks are full.
  - vec_out/vec_valid always reflect the oldest complete bank.
  - Sustained throughput is one vector per IN_DIM cycles; completed vectors are delivered in fill order.
  - A simultaneous output transfer and final-element fill in the same cycle: the held bank frees and the new bank becomes head next cycle, with no bubble.
- Not defined: single bank, exactly the behaviour above.

Test Plan:
- Reset/idle: assert rst_n low mid-fill, release -> all outputs 0; s_ready=1 one edge after release; vec_count=0.
- Basic fill (IN_DIM=4, DATA_W=8): send 0x11,0x22,0x33,0x44 with s_last on 0x44 -> vec_out=0x44332211, vec_valid high the cycle after the 4th transfer, frame_err stays 0.
- Backpressure: keep vec_ready=0 for 10 cycles -> vec_out stable, vec_valid=1, s_ready=0 throughout; vec_ready=1 -> one transfer, vec_count=1, s_ready=1 next cycle.
- Early s_last: send 0xAA,0xBB with s_last on 0xBB, then 4 valid bytes 1,2,3,4 -> frame_err pulses once; delivered vec_out=0x04030201.
- Missing s_last: 4 bytes with s_last=0 -> vector issued; frame_err single pulse aligned with vec_valid rise.
- Streaming with MLP_LOADER_DBUF_EN, vec_ready=1, s_valid=1 constant for 3 vectors -> vec_valid cadence every 4 cycles, vectors in order, vec_count=3, s_ready never drops.
